// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter in front of an asynchronous FIFO write port.
//   A granted requester owns the port for req_len+1 words. Writes are
//   throttled combinationally by wfull. Every burst gets a new burst_id.
//
//   Ports:
//     wclk, wrst    write clock, async active-high reset
//     req           per-requester burst request (level)
//     req_len       per-requester burst length minus one, LENW bits each
//     req_data      per-requester current data word, DSIZE bits each
//     wfull         FIFO full, synchronous to wclk
//     gnt           one-hot grant held for the whole burst
//     data_ack      one-hot pulse: that requester's word was written
//     winc, wdata   FIFO write strobe / data
//     burst_id      id of current or most recent burst
//     busy          a burst is in progress
//
//   Build option: WRARB_BACK2BACK_EN -- re-arbitrate on the completing beat
//   so consecutive bursts have no idle cycle between them.
module fifo_wr_arbiter #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4,
   parameter int LENW  = 4
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LENW-1:0]  req_len,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic                  wfull,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       data_ack,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [31:0]           burst_id,
   output logic                  busy
);

   localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NR = NREQ;

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   sel;
   logic [LENW-1:0] cnt;
   logic [PW-1:0]   win;
   logic            win_vld;
   logic [NREQ-1:0] win_oh;
   logic            last_beat;
   logic            arb_en;
   logic            load;

   // Round-robin search: first requester at or after ptr, wrapping.
   always_comb begin : arb
      int unsigned idx;
      idx     = '0;
      win     = '0;
      win_vld = 1'b0;
      for (int unsigned i = 0; i < NR; i++) begin
         idx = (32'(ptr) + i) % NR;
         if (!win_vld && req[idx[PW-1:0]]) begin
            win_vld = 1'b1;
            win     = idx[PW-1:0];
         end
      end
   end

   assign win_oh = NREQ'(1) << win;

   always_comb begin
      busy      = (state == BURST);
      winc      = busy && !wfull;
      wdata     = '0;
      data_ack  = '0;
      if (busy) begin
         wdata = req_data[int'(sel)*DSIZE +: DSIZE];
      end
      if (winc) begin
         data_ack = gnt;
      end
      last_beat = winc && (cnt == '0);
`ifdef WRARB_BACK2BACK_EN
      arb_en    = (state == IDLE) || last_beat;
`else
      arb_en    = (state == IDLE);
`endif
      load      = arb_en && win_vld;
   end

   always_comb begin
      state_nxt = state;
      if (load) begin
         state_nxt = BURST;
      end else if (last_beat) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state    <= IDLE;
         gnt      <= '0;
         burst_id <= '0;
         ptr      <= '0;
         sel      <= '0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            gnt      <= win_oh;
            sel      <= win;
            cnt      <= req_len[int'(win)*LENW +: LENW];
            burst_id <= burst_id + 32'd1;
            ptr      <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
         end else if (last_beat) begin
            gnt <= '0;
         end else if (winc) begin
            cnt <= cnt - LENW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int L = 4;
   localparam int D = 8;
`ifdef WRARB_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic            wclk = 1'b0;
   logic            wrst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*L-1:0]  req_len = '0;
   logic [N*D-1:0]  req_data = '0;
   logic            wfull = 1'b0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    data_ack;
   logic            winc;
   logic [D-1:0]    wdata;
   logic [31:0]     burst_id;
   logic            busy;

   fifo_wr_arbiter #(.DSIZE(D), .NREQ(N), .LENW(L)) dut (
      .wclk(wclk), .wrst(wrst), .req(req), .req_len(req_len),
      .req_data(req_data), .wfull(wfull), .gnt(gnt), .data_ack(data_ack),
      .winc(winc), .wdata(wdata), .burst_id(burst_id), .busy(busy)
   );

   always #5 wclk = ~wclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the port and how many words remain.
   bit          m_busy = 0;
   int          m_owner = 0;
   int          m_rem = 0;
   logic [31:0] m_id = '0;
   int          m_ptr = 0;

   always @(posedge wclk or posedge wrst) begin
      bit done;
      done = 0;
      if (wrst) begin
         m_busy = 0; m_owner = 0; m_rem = 0; m_id = '0; m_ptr = 0;
      end else begin
         if (m_busy && !wfull) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 0;
               done   = 1;
            end
         end
         if (!m_busy && (!done || B2B) && req != '0) begin
            for (int k = 0; k < N; k++) begin
               int idx;
               idx = (m_ptr + k) % N;
               if (!m_busy && req[idx]) begin
                  m_busy  = 1;
                  m_owner = idx;
                  m_rem   = int'(req_len[idx*L +: L]) + 1;
                  m_id    = m_id + 1;
                  m_ptr   = (idx + 1) % N;
               end
            end
         end
      end
   end

   // Requesters: each presents an incrementing word stream tagged with its index.
   logic [N-1:0] last_ack = '0;
   int           word_no [N];
   initial for (int i = 0; i < N; i++) word_no[i] = 0;
   always @(posedge wclk) begin
      #2;
      for (int i = 0; i < N; i++) begin
         logic [7:0] w;
         if (last_ack[i]) word_no[i]++;
         w = 8'(i * 64 + (word_no[i] % 64));
         req_data[i*D +: D] = w;
      end
   end

   // Logs of observed activity, consumed by the directed checks.
   int          glog[$];
   logic [31:0] idlog[$];
   int          gaps[$];
   int          cyc[$];
   int          wrs[$];
   logic [7:0]  wq[$];
   int          ackcnt [N];
   bit          pbusy = 0;
   logic [31:0] pid = '0;
   bit          open_b = 0;
   int          cur_cyc = 0, cur_wr = 0, idle_run = 0;

   task automatic clr();
      glog.delete(); idlog.delete(); gaps.delete(); cyc.delete(); wrs.delete(); wq.delete();
      for (int i = 0; i < N; i++) ackcnt[i] = 0;
      open_b = 0; idle_run = 0;
   endtask

   // Single compare process: every cycle, DUT outputs against the model.
   always @(negedge wclk) begin
      logic [N-1:0] e_gnt;
      logic         e_winc;
      e_gnt  = m_busy ? N'(1) << m_owner : '0;
      e_winc = m_busy && !wfull;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("winc", 32'(winc), 32'(e_winc));
      chk("data_ack", 32'(data_ack), e_winc ? 32'(e_gnt) : 32'd0);
      chk("wdata", 32'(wdata), m_busy ? 32'(req_data[m_owner*D +: D]) : 32'd0);
      chk("burst_id", burst_id, m_id);
      last_ack = data_ack;
      if (busy && (!pbusy || burst_id != pid)) begin
         if (open_b) begin cyc.push_back(cur_cyc); wrs.push_back(cur_wr); end
         open_b = 1; cur_cyc = 0; cur_wr = 0;
         for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
         idlog.push_back(burst_id);
         gaps.push_back(idle_run);
         idle_run = 0;
      end
      if (busy) begin
         cur_cyc++;
         if (winc) begin cur_wr++; wq.push_back(wdata); end
      end else begin
         if (open_b) begin cyc.push_back(cur_cyc); wrs.push_back(cur_wr); open_b = 0; end
         idle_run++;
      end
      for (int i = 0; i < N; i++) if (data_ack[i]) ackcnt[i]++;
      pbusy = busy;
      pid   = burst_id;
   end

   task automatic step();
      @(posedge wclk);
      #2;
   endtask

   task automatic wait_idle(input int limit);
      bit ok;
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         step();
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) chk("wait_idle_timeout", 32'd1, 32'd0);
      @(negedge wclk);
      #1;
   endtask

   task automatic do_reset();
      step();
      wrst = 1'b1; req = '0; wfull = 1'b0;
      step();
      wrst = 1'b0;
      step();
      clr();
   endtask

   initial begin
      // Reset held with random inputs: everything must be quiet.
      for (int i = 0; i < 3; i++) begin
         step();
         req = 4'($urandom); req_len = 16'($urandom); wfull = 1'($urandom);
         #1;
         chk("rst_outputs", {gnt, data_ack, winc, wdata, busy}, '0);
         chk("rst_burst_id", burst_id, 32'd0);
      end

      // First burst after reset: requester 2, 4 words.
      step();
      clr();
      wrst = 1'b0; wfull = 1'b0; req = 4'b0100; req_len = '0; req_len[2*L +: L] = 4'd3;
      step();
      req = '0;
      wait_idle(20);
      chk("t1_nbursts", glog.size(), 1);
      chk("t1_winner", glog.size() > 0 ? glog[0] : -1, 2);
      chk("t1_gnt_cycles", cyc.size() > 0 ? cyc[0] : -1, 4);
      chk("t1_writes", wrs.size() > 0 ? wrs[0] : -1, 4);
      chk("t1_burst_id", burst_id, 32'd1);

      // Full stall for two cycles after the 2nd word.
      do_reset();
      req = 4'b0001; req_len = '0; req_len[0 +: L] = 4'd3;
      step();
      req = '0;
      step();
      step(); wfull = 1'b1;
      step();
      step(); wfull = 1'b0;
      wait_idle(20);
      chk("t2_cycles", cyc.size() > 0 ? cyc[0] : -1, 6);
      chk("t2_writes", wrs.size() > 0 ? wrs[0] : -1, 4);
      chk("t2_nwords", wq.size(), 4);
      for (int i = 1; i < wq.size(); i++)
         chk("t2_order", 32'(wq[i]), 32'(wq[0] + 8'(i)));
      chk("t2_owner", wq.size() > 0 ? 32'(wq[0][7:6]) : 32'hx, 32'd0);

      // Fairness with all requests held, single-word bursts.
      do_reset();
      req = 4'b1111; req_len = '0;
      for (int i = 0; i < 40 && glog.size() < 5; i++) step();
      req = '0;
      wait_idle(20);
      chk("t3_nbursts_ge5", 32'(glog.size() >= 5), 32'd1);
      for (int i = 0; i < 5 && i < glog.size(); i++) begin
         chk("t3_order", glog[i], i % N);
         chk("t3_id", idlog[i], 32'(i + 1));
         if (i > 0) chk("t3_gap", gaps[i], B2B ? 0 : 1);
      end

      // Withdrawal: requester 1 drops req mid-burst of 8.
      do_reset();
      req = 4'b0010; req_len = '0; req_len[1*L +: L] = 4'd7;
      step();
      step();
      req = '0; req_len = 16'($urandom);
      wait_idle(30);
      chk("t4_writes", wrs.size() > 0 ? wrs[0] : -1, 8);

      // Reset after the 3rd word: immediate shutdown.
      do_reset();
      req = 4'b0001; req_len = '0; req_len[0 +: L] = 4'd7;
      step();
      req = '0;
      step(); step(); step();
      wrst = 1'b1;
      #1;
      chk("t4_rst_winc", 32'(winc), 32'd0);
      chk("t4_rst_gnt", 32'(gnt), 32'd0);
      chk("t4_rst_id", burst_id, 32'd0);
      chk("t4_words_before_rst", wq.size(), 3);
      step();
      wrst = 1'b0;
      step();

      // burst_id wrap.
      clr();
      force dut.burst_id = 32'hFFFF_FFFF;
      m_id = 32'hFFFF_FFFF;
      #1;
      release dut.burst_id;
      step();
      req = 4'b1000; req_len = '0;
      step();
      req = '0;
      #1;
      chk("t5_wrap_id", burst_id, 32'd0);
      wait_idle(20);

      // Maximum burst length.
      do_reset();
      req = 4'b0100; req_len = '0; req_len[2*L +: L] = 4'hF;
      step();
      req = '0;
      wait_idle(30);
      chk("t6_writes", wrs.size() > 0 ? wrs[0] : -1, 16);
      for (int i = 0; i < N; i++) chk("t6_ack", ackcnt[i], (i == 2) ? 16 : 0);

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 600; i++) begin
         req     = 4'($urandom_range(0, 15));
         req_len = 16'($urandom);
         wfull   = ($urandom_range(0, 3) == 0);
         wrst    = ($urandom_range(0, 149) == 0);
         step();
      end
      wrst = 1'b0; req = '0; wfull = 1'b0;
      wait_idle(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter that shares the asynchronous FIFO write port among `NREQ` requesters in the write clock domain. Each granted requester owns the port for a whole burst of 1..2^`LENW` words. The arbiter drives `winc`/`wdata` directly into the FIFO write interface and throttles on `wfull`. It tags every burst with an incrementing `burst_id` for scoreboard correlation.

## Interface
- `DSIZE`, 8: data width, matching the FIFO write data width.
- `NREQ`, 4: number of requesters, 2..8.
- `LENW`, 4: burst length field width; burst length = `req_len` + 1.

- `wclk`  in  1  write-domain clock.
- `wrst`  in  1  reset, asynchronous, active-high; single clock domain (`wclk`).
- `req`  in  NREQ  per-requester burst request, level.
- `req_len`  in  NREQ*LENW  per-requester burst length minus one; slice i = bits [i*LENW +: LENW].
- `req_data`  in  NREQ*DSIZE  per-requester current data word; slice i = bits [i*DSIZE +: DSIZE].
- `wfull`  in  1  FIFO full flag, already synchronized to `wclk`.
- `gnt`  out  NREQ  one-hot grant, held for the whole burst.
- `data_ack`  out  NREQ  one-hot pulse: the requester's current word was written this cycle, so it must present the next word.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `burst_id`  out  32  ID of the current or most recent burst.
- `busy`  out  1  high while in the BURST state.

## Operation
- FSM states: IDLE, BURST.
- **IDLE:** when any `req` bit is set, select the winner by round-robin.
  - Search starts at `ptr`, wrapping modulo `NREQ`.
  - At the next edge:
    - `gnt` <= onehot(winner)
    - `cnt` <= `req_len[winner]`
    - `burst_id` <= `burst_id` + 1 (wraps 2^32-1 -> 0)
    - `ptr` <= (winner+1) mod `NREQ`
    - state <= BURST
- **BURST (combinational outputs):**
  - `winc` = ~`wfull`.
  - `wdata` = `req_data[sel]`.
  - `data_ack[sel]` = `winc`.
- **BURST (sequential):** on each cycle with `winc`=1:
  - if `cnt`==0, the burst is complete;
  - otherwise `cnt` <= `cnt`-1.
- **Burst complete:** state <= IDLE and `gnt` <= 0, unless back-to-back mode is enabled (see Configuration).
- **BURST outputs by cycle:** `winc` and `data_ack` are 0 in every cycle where `wfull`=1; nothing else changes in those cycles.
- **Request withdrawal:** `req` and `req_len` are ignored during BURST. Deasserting `req` mid-burst does not shorten the burst. Only the grant cycle samples `req_len`.
- **Outside BURST:** `winc`=0, `data_ack`=0, `wdata`=0.
- **Reset values:** state IDLE; `gnt`=0, `data_ack`=0, `winc`=0, `wdata`=0, `burst_id`=0, `busy`=0; `ptr`=0; `cnt`=0.
- **Reset mid-burst:** the burst is abandoned immediately and `winc` drops asynchronously. Any words already written remain in the FIFO.

## Timing
- **Grant latency:** `req` seen high in IDLE at edge k -> `gnt`, `busy` and the new `burst_id` are high from k+1. The first `winc` can occur in cycle k+1.
- **Throughput:** one word per cycle while `wfull`=0. A burst of L words with no stalls occupies exactly L BURST cycles.
- **Last-beat gap (macro off):** one IDLE cycle between consecutive bursts.
- **Combinational full path:** `wfull` -> `winc`/`data_ack` is combinational, so a write is never issued in a cycle where `wfull`=1.
- **Simultaneous requests:** the lowest index at or after `ptr` wins. With all requests held, grants rotate 0,1,2,3,0…

## Configuration
- `WRARB_BACK2BACK_EN`
  - **Defined:** on the completing beat, if any `req` is set, arbitration happens in that same cycle. The next edge loads the new `gnt`, `cnt`, `burst_id` and `ptr` and stays in BURST, so there is no idle gap. The just-finished requester is arbitrated with the updated `ptr`.
  - **Undefined:** the FSM always returns to IDLE for one cycle after each burst.

## Test plan
- **Reset check:** hold `wrst`=1 with random inputs -> all outputs 0. Release `wrst`, assert `req`=4'b0100 with `req_len[2]`=3 -> `gnt`=4'b0100 for exactly 4 cycles; `winc` high for 4 cycles; `burst_id`=1.
- **Full stall:** burst of 4 with `wfull` pulsed high for 2 cycles after the 2nd word -> `winc`=0 in both stall cycles; exactly 4 writes total; data order preserved; burst lasts 6 cycles.
- **Fairness:** `req`=4'b1111 held, every `req_len`=0 -> grant order 0,1,2,3,0; `burst_id` 1..5; an IDLE gap between bursts with the macro off and no gap with it on.
- **Withdrawal and reset:** requester 1 drops `req` mid-burst of length 8 -> 8 words are still written. Separately, assert `wrst` after the 3rd word -> `winc`/`gnt` go to 0 the same cycle and `burst_id`=0.
- **ID wrap:** force `burst_id` to 32'hFFFF_FFFF, then issue one grant -> `burst_id`=0.
- **Maximum length:** `req_len`=4'hF -> 16 writes, and `data_ack` pulses exactly 16 times to the granted requester only.
